// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: time-set controller for the watch datapath.
// Freezes the watch, edits shadow fields, commits with one load strobe.

// Wrapping up/down step for one shadow field whose legal range is 0..MAX.
module watch_set_field #(
   parameter int           W   = 6,
   parameter logic [W-1:0] MAX = '0
) (
   input  logic [W-1:0] i_v,
   input  logic         i_up,
   input  logic         i_dn,
   output logic [W-1:0] o_v
);

   // Out-of-range values normalize on the first edit in either direction.
   always_comb begin
      o_v = i_v;
      if (i_up && !i_dn) begin
         o_v = (i_v >= MAX) ? '0 : i_v + 1'b1;
      end else if (i_dn && !i_up) begin
         o_v = (i_v == '0 || i_v > MAX) ? MAX : i_v - 1'b1;
      end
   end

endmodule

module watch_set_ctrl #(
   parameter int                   P_COUNT_BIT   = 30,
   parameter logic [P_COUNT_BIT-1:0] P_TIMEOUT_CYC = 30'd100000000,
   parameter int                   P_SEC_BIT     = 6,
   parameter int                   P_MIN_BIT     = 6,
   parameter int                   P_HOUR_BIT    = 5,
   parameter int                   P_DAY_BIT     = 9,
   parameter int                   P_YEAR_BIT    = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_btn_mode,
   input  logic                  i_btn_up,
   input  logic                  i_btn_down,
   input  logic                  i_btn_cancel,
   input  logic [P_SEC_BIT-1:0]  i_cur_sec,
   input  logic [P_MIN_BIT-1:0]  i_cur_min,
   input  logic [P_HOUR_BIT-1:0] i_cur_hour,
   input  logic [P_DAY_BIT-1:0]  i_cur_day,
   input  logic [P_YEAR_BIT-1:0] i_cur_year,
   output logic                  o_run_en,
   output logic                  o_load,
   output logic [P_SEC_BIT-1:0]  o_set_sec,
   output logic [P_MIN_BIT-1:0]  o_set_min,
   output logic [P_HOUR_BIT-1:0] o_set_hour,
   output logic [P_DAY_BIT-1:0]  o_set_day,
   output logic [P_YEAR_BIT-1:0] o_set_year,
   output logic [2:0]            o_field_sel
);

   localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
   localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
   localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);
   localparam logic [P_DAY_BIT-1:0]  DAY_MAX  = P_DAY_BIT'(364);
   localparam logic [P_YEAR_BIT-1:0] YEAR_MAX = P_YEAR_BIT'(4095);

   localparam logic                   TMO_EN   = (P_TIMEOUT_CYC != '0);
   localparam logic [P_COUNT_BIT-1:0] TMO_LAST = P_TIMEOUT_CYC - 1'b1;

   typedef enum logic [2:0] {
      S_RUN,
      S_YEAR,
      S_DAY,
      S_HOUR,
      S_MIN,
      S_SEC,
      S_LOAD
   } state_t;

   state_t                  state_q, state_d;
   logic [P_COUNT_BIT-1:0]  cnt_q, cnt_d;
   logic [P_SEC_BIT-1:0]    sec_q, sec_d, sec_nxt;
   logic [P_MIN_BIT-1:0]    min_q, min_d, min_nxt;
   logic [P_HOUR_BIT-1:0]   hour_q, hour_d, hour_nxt;
   logic [P_DAY_BIT-1:0]    day_q, day_d, day_nxt;
   logic [P_YEAR_BIT-1:0]   year_q, year_d, year_nxt;
   logic                    run_en_q, run_en_d;
   logic                    load_q, load_d;
   logic [2:0]              sel_q, sel_d;

   logic any_btn;
   logic in_set_q;
   logic in_set_d;
   logic capture;
   logic edit_ok;
   logic tmo_hit;

   assign any_btn  = i_btn_mode | i_btn_up | i_btn_down | i_btn_cancel;
   assign in_set_q = (state_q != S_RUN) && (state_q != S_LOAD);
   assign in_set_d = (state_d != S_RUN) && (state_d != S_LOAD);
   assign capture  = (state_q == S_RUN) && i_btn_mode;
   assign edit_ok  = in_set_q && !i_btn_cancel && !i_btn_mode;
   assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST);

   watch_set_field #(.W(P_YEAR_BIT), .MAX(YEAR_MAX)) u_year (
      .i_v  (year_q),
      .i_up (edit_ok && state_q == S_YEAR && i_btn_up),
      .i_dn (edit_ok && state_q == S_YEAR && i_btn_down),
      .o_v  (year_nxt)
   );

   watch_set_field #(.W(P_DAY_BIT), .MAX(DAY_MAX)) u_day (
      .i_v  (day_q),
      .i_up (edit_ok && state_q == S_DAY && i_btn_up),
      .i_dn (edit_ok && state_q == S_DAY && i_btn_down),
      .o_v  (day_nxt)
   );

   watch_set_field #(.W(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
      .i_v  (hour_q),
      .i_up (edit_ok && state_q == S_HOUR && i_btn_up),
      .i_dn (edit_ok && state_q == S_HOUR && i_btn_down),
      .o_v  (hour_nxt)
   );

   watch_set_field #(.W(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
      .i_v  (min_q),
      .i_up (edit_ok && state_q == S_MIN && i_btn_up),
      .i_dn (edit_ok && state_q == S_MIN && i_btn_down),
      .o_v  (min_nxt)
   );

   watch_set_field #(.W(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
      .i_v  (sec_q),
      .i_up (edit_ok && state_q == S_SEC && i_btn_up),
      .i_dn (edit_ok && state_q == S_SEC && i_btn_down),
      .o_v  (sec_nxt)
   );

   // Next state: cancel beats mode beats edits; timeout only on quiet cycles.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:  if (i_btn_mode) state_d = S_YEAR;
         S_LOAD: state_d = S_RUN;
         default: begin
            if (i_btn_cancel) begin
               state_d = S_RUN;
            end else if (i_btn_mode) begin
               unique case (state_q)
                  S_YEAR:  state_d = S_DAY;
                  S_DAY:   state_d = S_HOUR;
                  S_HOUR:  state_d = S_MIN;
                  S_MIN:   state_d = S_SEC;
                  default: state_d = S_LOAD;
               endcase
            end else if (!any_btn && tmo_hit) begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   // Inactivity counter, shadow capture/edit and registered output values.
   always_comb begin
      cnt_d = '0;
      if (TMO_EN && in_set_d && !any_btn && state_d == state_q) begin
         cnt_d = cnt_q + 1'b1;
      end

      year_d = capture ? i_cur_year : year_nxt;
      day_d  = capture ? i_cur_day  : day_nxt;
      hour_d = capture ? i_cur_hour : hour_nxt;
      min_d  = capture ? i_cur_min  : min_nxt;
      sec_d  = capture ? i_cur_sec  : sec_nxt;

      run_en_d = (state_d == S_RUN);
      load_d   = (state_d == S_LOAD);
      unique case (state_d)
         S_YEAR:  sel_d = 3'd1;
         S_DAY:   sel_d = 3'd2;
         S_HOUR:  sel_d = 3'd3;
         S_MIN:   sel_d = 3'd4;
         S_SEC:   sel_d = 3'd5;
         default: sel_d = 3'd0;
      endcase
   end

   // State, counter, shadows and outputs; reset parks in RUN, watch stopped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_RUN;
         cnt_q    <= '0;
         year_q   <= '0;
         day_q    <= '0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
         run_en_q <= 1'b0;
         load_q   <= 1'b0;
         sel_q    <= 3'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         year_q   <= year_d;
         day_q    <= day_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         run_en_q <= run_en_d;
         load_q   <= load_d;
         sel_q    <= sel_d;
      end
   end

   assign o_run_en    = run_en_q;
   assign o_load      = load_q;
   assign o_field_sel = sel_q;
   assign o_set_year  = year_q;
   assign o_set_day   = day_q;
   assign o_set_hour  = hour_q;
   assign o_set_min   = min_q;
   assign o_set_sec   = sec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed and random checks of watch_set_ctrl
// against a field-level behavioural model of the set procedure.

module tb_watch_set_ctrl;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_btn_mode = 1'b0;
   logic        i_btn_up = 1'b0;
   logic        i_btn_down = 1'b0;
   logic        i_btn_cancel = 1'b0;
   logic [5:0]  i_cur_sec, i_cur_min;
   logic [4:0]  i_cur_hour;
   logic [8:0]  i_cur_day;
   logic [11:0] i_cur_year;
   logic        o_run_en, o_load;
   logic [5:0]  o_set_sec, o_set_min;
   logic [4:0]  o_set_hour;
   logic [8:0]  o_set_day;
   logic [11:0] o_set_year;
   logic [2:0]  o_field_sel;

   int checks = 0;
   int failures = 0;
   int loads = 0;

   // index 1 = year, 2 = day, 3 = hour, 4 = min, 5 = sec
   int mods [1:5] = '{4096, 365, 24, 60, 60};
   int cur  [1:5] = '{0, 0, 0, 0, 0};
   int sh   [1:5];
   int phase;  // 0 run, 1..5 editing field, 6 committing
   int quiet;  // consecutive button-free cycles in the current field
   logic [31:0] e_run, e_load, e_sel;

   always #5 clk = ~clk;

   assign i_cur_year = 12'(cur[1]);
   assign i_cur_day  = 9'(cur[2]);
   assign i_cur_hour = 5'(cur[3]);
   assign i_cur_min  = 6'(cur[4]);
   assign i_cur_sec  = 6'(cur[5]);

   watch_set_ctrl #(.P_TIMEOUT_CYC(30'd16)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_btn_mode   (i_btn_mode),
      .i_btn_up     (i_btn_up),
      .i_btn_down   (i_btn_down),
      .i_btn_cancel (i_btn_cancel),
      .i_cur_sec    (i_cur_sec),
      .i_cur_min    (i_cur_min),
      .i_cur_hour   (i_cur_hour),
      .i_cur_day    (i_cur_day),
      .i_cur_year   (i_cur_year),
      .o_run_en     (o_run_en),
      .o_load       (o_load),
      .o_set_sec    (o_set_sec),
      .o_set_min    (o_set_min),
      .o_set_hour   (o_set_hour),
      .o_set_day    (o_set_day),
      .o_set_year   (o_set_year),
      .o_field_sel  (o_field_sel)
   );

   task automatic chk(input string tag, input string what,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0d expected=%0d",
                tag, what, obs, exp);
      end
   endtask

   task automatic model_reset();
      phase = 0;
      quiet = 0;
      for (int k = 1; k <= 5; k++) sh[k] = 0;
      e_run = 0;
      e_load = 0;
      e_sel = 0;
   endtask

   task automatic model_edge(input logic m, u, d, c);
      if (phase == 0) begin
         if (m) begin
            for (int k = 1; k <= 5; k++) sh[k] = cur[k];
            phase = 1;
         end
      end else if (phase == 6) begin
         phase = 0;
      end else begin
         if (c) phase = 0;
         else if (m) phase = phase + 1;
         else if (u && !d)
            sh[phase] = (sh[phase] >= mods[phase] - 1) ? 0 : sh[phase] + 1;
         else if (d && !u)
            sh[phase] = (sh[phase] == 0 || sh[phase] >= mods[phase])
                        ? mods[phase] - 1 : sh[phase] - 1;
         else if (!u && !d && quiet == T - 1) phase = 0;
         else if (!u && !d) quiet++;
         if (m || u || d || c) quiet = 0;
      end
      if (phase < 1 || phase > 5) quiet = 0;
      e_run  = (phase == 0);
      e_load = (phase == 6);
      e_sel  = (phase >= 1 && phase <= 5) ? phase : 0;
   endtask

   task automatic check_all(input string tag);
      chk(tag, "run_en", 32'(o_run_en), e_run);
      chk(tag, "load", 32'(o_load), e_load);
      chk(tag, "field_sel", 32'(o_field_sel), e_sel);
      chk(tag, "year", 32'(o_set_year), sh[1]);
      chk(tag, "day", 32'(o_set_day), sh[2]);
      chk(tag, "hour", 32'(o_set_hour), sh[3]);
      chk(tag, "min", 32'(o_set_min), sh[4]);
      chk(tag, "sec", 32'(o_set_sec), sh[5]);
   endtask

   task automatic step(input logic m, u, d, c, input string tag);
      @(negedge clk);
      i_btn_mode   = m;
      i_btn_up     = u;
      i_btn_down   = d;
      i_btn_cancel = c;
      @(posedge clk);
      model_edge(m, u, d, c);
      #1;
      if (o_load === 1'b1) loads++;
      check_all(tag);
   endtask

   task automatic set_cur(input int y, dy, h, mi, s);
      cur[1] = y;
      cur[2] = dy;
      cur[3] = h;
      cur[4] = mi;
      cur[5] = s;
   endtask

   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, 0, {tag, "_rel"});
      chk(tag, "run_after_rel", 32'(o_run_en), 1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, 0, "rel");
      chk("rel", "run_first_edge", 32'(o_run_en), 1);

      // full edit sequence
      set_cur(2024, 100, 23, 59, 59);
      loads = 0;
      step(1, 0, 0, 0, "edit");
      chk("edit", "capt_year", 32'(o_set_year), 2024);
      chk("edit", "capt_sel", 32'(o_field_sel), 1);
      step(0, 1, 0, 0, "edit");
      step(1, 0, 0, 0, "edit");
      repeat (101) step(0, 0, 1, 0, "edit");
      step(1, 0, 0, 0, "edit");
      step(0, 1, 0, 0, "edit");
      step(1, 0, 0, 0, "edit");
      step(0, 1, 0, 0, "edit");
      step(1, 0, 0, 0, "edit");
      step(0, 1, 0, 0, "edit");
      step(1, 0, 0, 0, "edit");
      chk("edit", "load", 32'(o_load), 1);
      chk("edit", "run_in_load", 32'(o_run_en), 0);
      chk("edit", "year", 32'(o_set_year), 2025);
      chk("edit", "day", 32'(o_set_day), 364);
      chk("edit", "hour", 32'(o_set_hour), 0);
      chk("edit", "min", 32'(o_set_min), 0);
      chk("edit", "sec", 32'(o_set_sec), 0);
      step(0, 0, 0, 0, "edit");
      chk("edit", "run_after", 32'(o_run_en), 1);
      chk("edit", "load_count", loads, 1);

      // wraps
      set_cur(2024, 100, 23, 59, 0);
      step(1, 0, 0, 0, "wrap");
      repeat (4) step(1, 0, 0, 0, "wrap");
      chk("wrap", "sel_sec", 32'(o_field_sel), 5);
      step(0, 0, 1, 0, "wrap");
      chk("wrap", "sec_dn0", 32'(o_set_sec), 59);
      step(0, 1, 0, 0, "wrap");
      chk("wrap", "sec_up59", 32'(o_set_sec), 0);
      step(0, 0, 0, 1, "wrap");
      set_cur(4095, 1, 1, 1, 1);
      step(1, 0, 0, 0, "wrap");
      step(0, 1, 0, 0, "wrap");
      chk("wrap", "year_up4095", 32'(o_set_year), 0);
      step(0, 0, 0, 1, "wrap");
      set_cur(5, 5, 5, 5, 63);
      step(1, 0, 0, 0, "wrap");
      repeat (4) step(1, 0, 0, 0, "wrap");
      step(0, 1, 0, 0, "wrap");
      chk("wrap", "sec63_up", 32'(o_set_sec), 0);
      step(0, 0, 0, 1, "wrap");
      step(1, 0, 0, 0, "wrap");
      repeat (4) step(1, 0, 0, 0, "wrap");
      step(0, 0, 1, 0, "wrap");
      chk("wrap", "sec63_dn", 32'(o_set_sec), 59);
      step(0, 0, 0, 1, "wrap");

      // cancel in SET_MIN after edits
      set_cur(1000, 200, 10, 30, 20);
      loads = 0;
      step(1, 0, 0, 0, "cancel");
      step(0, 1, 0, 0, "cancel");
      repeat (3) step(1, 0, 0, 0, "cancel");
      step(0, 1, 0, 0, "cancel");
      chk("cancel", "sel_min", 32'(o_field_sel), 4);
      step(0, 0, 0, 1, "cancel");
      chk("cancel", "run", 32'(o_run_en), 1);
      step(0, 0, 0, 0, "cancel");
      chk("cancel", "load_count", loads, 0);

      // timeout: up at cycle 10 of SET_DAY, abort 16 cycles later
      step(1, 0, 0, 0, "tmo");
      step(1, 0, 0, 0, "tmo");
      repeat (9) step(0, 0, 0, 0, "tmo");
      step(0, 1, 0, 0, "tmo");
      repeat (15) step(0, 0, 0, 0, "tmo");
      chk("tmo", "still_day", 32'(o_field_sel), 2);
      chk("tmo", "still_stopped", 32'(o_run_en), 0);
      loads = 0;
      step(0, 0, 0, 0, "tmo");
      chk("tmo", "abort_run", 32'(o_run_en), 1);
      chk("tmo", "abort_load", loads, 0);

      // simultaneous inputs
      set_cur(300, 50, 12, 40, 20);
      step(1, 0, 0, 0, "simul");
      step(0, 1, 1, 0, "simul");
      chk("simul", "updn_year", 32'(o_set_year), 300);
      step(1, 0, 0, 0, "simul");
      step(1, 0, 0, 0, "simul");
      step(1, 1, 0, 0, "simul");
      chk("simul", "modeup_sel", 32'(o_field_sel), 4);
      chk("simul", "modeup_hour", 32'(o_set_hour), 12);
      step(1, 0, 0, 0, "simul");
      loads = 0;
      step(1, 0, 0, 1, "simul");
      chk("simul", "cancelmode_run", 32'(o_run_en), 1);
      step(0, 0, 0, 0, "simul");
      chk("simul", "cancelmode_load", loads, 0);

      // asynchronous reset mid-SET_HOUR
      set_cur(1999, 10, 8, 7, 6);
      repeat (3) step(1, 0, 0, 0, "arst");
      step(0, 1, 0, 0, "arst");
      chk("arst", "sel_hour", 32'(o_field_sel), 3);
      async_reset("arst");

      // randomized traffic, alternating busy and quiet stretches
      for (int i = 0; i < 4000; i++) begin
         bit dense;
         logic m, u, d, c;
         dense = ((i / 400) % 2) == 0;
         if ($urandom_range(0, 7) == 0) begin
            cur[1] = $urandom_range(0, 4095);
            cur[2] = $urandom_range(0, 511);
            cur[3] = $urandom_range(0, 31);
            cur[4] = $urandom_range(0, 63);
            cur[5] = $urandom_range(0, 63);
         end
         m = $urandom_range(0, 99) < (dense ? 12 : 2);
         u = $urandom_range(0, 99) < (dense ? 30 : 3);
         d = $urandom_range(0, 99) < (dense ? 30 : 3);
         c = $urandom_range(0, 99) < (dense ? 2 : 1);
         step(m, u, d, c, "rand");
         if (i % 997 == 500) async_reset("rand_arst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
